crash_course_cpu_sequencer: RTL and testbench
=============================================

Name: crash_course_cpu_sequencer

Overview:
Parametrised program sequencer for the crash-course CPU, the next generation of the fixed 8-bit program counter. It has parametrised address width, call-stack depth and condition-flag count. It adds PC-relative branching, a stall input, explicit run-state control, and sticky stack overflow/underflow fault detection. It sits between the decoder (jump/branch/call/return controls), the ALU flag register and the instruction memory address port.

Parameters:
ADDR_WIDTH, 8, width of program counter and branch destination
STACK_DEPTH, 4, number of return-address entries in the internal call stack (>=1)
FLAG_COUNT, 2, number of condition flags from the flag register (>=1)
RESET_ADDR, 0, PC value loaded on reset and on fault clear

Ports:
clk  in  1  system clock
clk_en  in  1  clock enable; no state changes when low (except sync_rst)
sync_rst  in  1  synchronous active-high reset
system_start  in  1  leave IDLE and begin fetching
system_enabled  in  1  permits PC advance while in RUN
stall  in  1  hold PC and stack this cycle (pipeline back-pressure)
jump_enable  in  1  unconditional transfer (with call/return qualifiers)
branch_enable  in  1  conditional transfer
branch_relative  in  1  destination is a signed two's-complement offset from current PC
branch_destination  in  ADDR_WIDTH  absolute target or signed offset
branch_condition  in  CSEL_W+1  [CSEL_W-1:0] flag select, MSB inverts; CSEL_W = $clog2(FLAG_COUNT+1)
call_enable  in  1  with jump_enable: push return address then jump
return_enable  in  1  with jump_enable: pop and jump to popped address
flag_register  in  FLAG_COUNT  ALU condition flags
fault_clear  in  1  leave FAULT, return to IDLE
program_counter  out  ADDR_WIDTH  current fetch address
stack_depth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
stack_empty  out  1  stack_depth == 0
stack_full  out  1  stack_depth == STACK_DEPTH
fault  out  1  high while in FAULT
fault_cause  out  2  01 overflow, 10 underflow, 00 none

Behaviour:
- Reset: state=IDLE, program_counter=RESET_ADDR, stack_depth=0, fault=0, fault_cause=00. Stack contents are not reset.
- States: IDLE, RUN, FAULT. Advance, defined below, is the condition clk_en && state==RUN && system_enabled && ~stall.
- IDLE: PC holds RESET_ADDR. On clk_en && system_start, go to RUN with PC unchanged, so the first fetch is RESET_ADDR. Control inputs are ignored in IDLE.
- RUN, no advance: all state holds.
- RUN, advance: next PC uses this priority:
  - return (jump_enable && return_enable): if empty, go to FAULT, fault_cause=10, PC holds. Otherwise PC = top entry, depth-1.
  - call (jump_enable && call_enable && ~return_enable): if full, go to FAULT, fault_cause=01, PC holds, no push. Otherwise push PC+1, depth+1, PC = target.
  - jump (jump_enable alone): PC = target.
  - branch_enable && condition_met: PC = target.
  - Otherwise PC = PC+1.
- condition_met = branch_condition[MSB] XOR sel. sel=0 when flag select==0, sel=flag_register[select-1] for 1..FLAG_COUNT, sel=0 for out-of-range selects. Select 0 with inversion set gives "always".
- target = branch_relative ? PC + sign-extended offset : branch_destination. This applies to jump, branch and call alike.
- All PC arithmetic is modulo 2^ADDR_WIDTH. Increment wraps from all-ones to 0. A pushed return address wraps the same way.
- FAULT: PC, stack and cause are frozen. fault_clear && clk_en goes to IDLE with PC=RESET_ADDR, depth=0, cause=00.
- sync_rst overrides everything regardless of clk_en or stall.
- Latency: program_counter is registered; it reflects a decision one clk_en cycle after the controls are sampled.

Decomposition:
- Package crash_course_cpu_pkg holds:
  - sequencer state enum (IDLE/RUN/FAULT)
  - fault_cause encoding constants
  - condition-select constants (COND_NONE=0)
- Sub-module crash_course_cpu_return_stack (parametrised LIFO):
  - push, pop, push_data, top_data, depth, full, empty
  - ignores push when full and pop when empty
  - the sequencer owns fault detection

Test Plan:
- Reset then system_start, system_enabled=1, no controls, 300 cycles, ADDR_WIDTH=8 -> PC counts 0..255, wraps to 0, continues.
- PC=0x10, jump_enable+call_enable, destination 0x40 -> PC=0x40, depth=1. Later jump+return -> PC=0x11, depth=0.
- Relative branch at PC=0x05, offset 0xFE, condition select 0 with invert bit -> PC=0x03. Flag select 1 with flag_register[0]=0, no invert -> PC=0x06.
- STACK_DEPTH=4: five consecutive calls -> fifth enters FAULT, cause=01, PC and depth=4 frozen. fault_clear -> IDLE, PC=RESET_ADDR, depth=0.
- Return with empty stack -> FAULT, cause=10. stall=1 during a call cycle -> PC and depth unchanged until stall drops.
- sync_rst asserted mid-run with clk_en=0 and stall=1 -> next cycle PC=RESET_ADDR, state IDLE, fault=0.

Source files
------------

// File: rtl/crash_course_cpu_pkg.sv
// rtl/crash_course_cpu_pkg.sv - shared types and encodings for the crash-course CPU sequencer
package crash_course_cpu_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_FAULT = 2'd2
    } seq_state_e;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_OVERFLOW  = 2'b01;
    localparam logic [1:0] CAUSE_UNDERFLOW = 2'b10;

    // Flag select value that never reads a flag; with the invert bit it means "always"
    localparam int COND_NONE = 0;

endpackage

// File: rtl/crash_course_cpu_return_stack.sv
// rtl/crash_course_cpu_return_stack.sv - parametrised LIFO of return addresses
module crash_course_cpu_return_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int DEPTH_W    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] top_data,
    output logic [DEPTH_W-1:0]    depth,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_W-1:0]    depth_q;
    logic [DEPTH_W-1:0]    depth_d;

    assign full  = (depth_q == DEPTH_W'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (clr) begin
            depth_d = '0;
        end else if (push && !full) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry contents are deliberately left unreset; only depth decides validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst && !clr && push && !full && depth_q == DEPTH_W'(i)) begin
                mem_q[i] <= push_data;
            end
        end
    end

    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top_data = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/crash_course_cpu_sequencer.sv
// rtl/crash_course_cpu_sequencer.sv - program counter sequencer with call stack and fault detection
module crash_course_cpu_sequencer
    import crash_course_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4,
    parameter int FLAG_COUNT  = 2,
    parameter int RESET_ADDR  = 0,
    parameter int CSEL_W      = $clog2(FLAG_COUNT + 1),
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  clk_en,
    input  logic                  sync_rst,
    input  logic                  system_start,
    input  logic                  system_enabled,
    input  logic                  stall,
    input  logic                  jump_enable,
    input  logic                  branch_enable,
    input  logic                  branch_relative,
    input  logic [ADDR_WIDTH-1:0] branch_destination,
    input  logic [CSEL_W:0]       branch_condition,
    input  logic                  call_enable,
    input  logic                  return_enable,
    input  logic [FLAG_COUNT-1:0] flag_register,
    input  logic                  fault_clear,
    output logic [ADDR_WIDTH-1:0] program_counter,
    output logic [DEPTH_W-1:0]    stack_depth,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  fault,
    output logic [1:0]            fault_cause
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_ADDR);

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [1:0]            cause_q, cause_d;

    logic                  stk_push, stk_pop, stk_clr;
    logic [ADDR_WIDTH-1:0] stk_top;
    logic                  stk_full, stk_empty;

    logic [CSEL_W-1:0]     cond_sel;
    logic                  sel_flag;
    logic                  cond_met;
    logic                  advance;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] target;

    assign cond_sel = branch_condition[CSEL_W-1:0];

    // Out-of-range selects read as 0, so they only ever act through the invert bit
    always_comb begin
        sel_flag = 1'b0;
        for (int i = COND_NONE + 1; i <= FLAG_COUNT; i++) begin
            if (cond_sel == CSEL_W'(i)) begin
                sel_flag = flag_register[i-1];
            end
        end
    end

    assign cond_met = branch_condition[CSEL_W] ^ sel_flag;
    assign advance  = clk_en && (state_q == SEQ_RUN) && system_enabled && !stall;
    assign pc_inc   = pc_q + ADDR_WIDTH'(1);
    // Offset is already PC-wide, so a plain modulo add is the sign-extended add
    assign target   = branch_relative ? (pc_q + branch_destination) : branch_destination;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cause_d  = cause_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        if (clk_en) begin
            case (state_q)
                SEQ_IDLE: begin
                    pc_d = RESET_PC;
                    if (system_start) begin
                        state_d = SEQ_RUN;
                    end
                end
                SEQ_RUN: begin
                    if (advance) begin
                        if (jump_enable && return_enable) begin
                            if (stk_empty) begin
                                state_d = SEQ_FAULT;
                                cause_d = CAUSE_UNDERFLOW;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = stk_top;
                            end
                        end else if (jump_enable && call_enable) begin
                            if (stk_full) begin
                                state_d = SEQ_FAULT;
                                cause_d = CAUSE_OVERFLOW;
                            end else begin
                                stk_push = 1'b1;
                                pc_d     = target;
                            end
                        end else if (jump_enable) begin
                            pc_d = target;
                        end else if (branch_enable && cond_met) begin
                            pc_d = target;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                end
                SEQ_FAULT: begin
                    if (fault_clear) begin
                        state_d = SEQ_IDLE;
                        pc_d    = RESET_PC;
                        cause_d = CAUSE_NONE;
                        stk_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = SEQ_IDLE;
                    pc_d    = RESET_PC;
                    cause_d = CAUSE_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= SEQ_IDLE;
            pc_q    <= RESET_PC;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    crash_course_cpu_return_stack #(
        .DATA_WIDTH (ADDR_WIDTH),
        .DEPTH      (STACK_DEPTH),
        .DEPTH_W    (DEPTH_W)
    ) u_return_stack (
        .clk       (clk),
        .rst       (sync_rst),
        .clr       (stk_clr),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .depth     (stack_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign program_counter = pc_q;
    assign stack_empty     = stk_empty;
    assign stack_full      = stk_full;
    assign fault           = (state_q == SEQ_FAULT);
    assign fault_cause     = cause_q;

endmodule

// File: tb/tb_crash_course_cpu_sequencer.sv
// tb/tb_crash_course_cpu_sequencer.sv - directed self-checking bench for the sequencer
module tb_crash_course_cpu_sequencer;

    logic       clk = 1'b0;
    logic       clk_en;
    logic       sync_rst;
    logic       system_start;
    logic       system_enabled;
    logic       stall;
    logic       jump_enable;
    logic       branch_enable;
    logic       branch_relative;
    logic [7:0] branch_destination;
    logic [2:0] branch_condition;
    logic       call_enable;
    logic       return_enable;
    logic [1:0] flag_register;
    logic       fault_clear;
    logic [7:0] program_counter;
    logic [2:0] stack_depth;
    logic       stack_empty;
    logic       stack_full;
    logic       fault;
    logic [1:0] fault_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crash_course_cpu_sequencer dut (
        .clk                (clk),
        .clk_en             (clk_en),
        .sync_rst           (sync_rst),
        .system_start       (system_start),
        .system_enabled     (system_enabled),
        .stall              (stall),
        .jump_enable        (jump_enable),
        .branch_enable      (branch_enable),
        .branch_relative    (branch_relative),
        .branch_destination (branch_destination),
        .branch_condition   (branch_condition),
        .call_enable        (call_enable),
        .return_enable      (return_enable),
        .flag_register      (flag_register),
        .fault_clear        (fault_clear),
        .program_counter    (program_counter),
        .stack_depth        (stack_depth),
        .stack_empty        (stack_empty),
        .stack_full         (stack_full),
        .fault              (fault),
        .fault_cause        (fault_cause)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_controls();
        jump_enable        = 1'b0;
        branch_enable      = 1'b0;
        branch_relative    = 1'b0;
        branch_destination = 8'h00;
        branch_condition   = 3'b000;
        call_enable        = 1'b0;
        return_enable      = 1'b0;
        fault_clear        = 1'b0;
        stall              = 1'b0;
    endtask

    task automatic do_jump(input logic [7:0] dest);
        jump_enable        = 1'b1;
        branch_destination = dest;
        step();
        idle_controls();
    endtask

    task automatic do_call(input logic [7:0] dest);
        jump_enable        = 1'b1;
        call_enable        = 1'b1;
        branch_destination = dest;
        step();
        idle_controls();
    endtask

    task automatic do_return();
        jump_enable   = 1'b1;
        return_enable = 1'b1;
        step();
        idle_controls();
    endtask

    task automatic do_branch(input logic rel, input logic [7:0] dest, input logic [2:0] cond, input logic [1:0] flags);
        branch_enable      = 1'b1;
        branch_relative    = rel;
        branch_destination = dest;
        branch_condition   = cond;
        flag_register      = flags;
        step();
        idle_controls();
    endtask

    initial begin
        clk_en         = 1'b1;
        sync_rst       = 1'b1;
        system_start   = 1'b0;
        system_enabled = 1'b1;
        flag_register  = 2'b00;
        idle_controls();
        step();
        step();
        check("rst_pc", program_counter, 32'h00);
        check("rst_depth", stack_depth, 0);
        check("rst_empty", stack_empty, 1);
        check("rst_full", stack_full, 0);
        check("rst_fault", fault, 0);
        check("rst_cause", fault_cause, 0);

        sync_rst = 1'b0;
        step();
        check("idle_hold_pc", program_counter, 32'h00);
        system_start = 1'b1;
        step();
        system_start = 1'b0;
        check("start_first_fetch", program_counter, 32'h00);
        for (int k = 1; k <= 300; k++) begin
            step();
            check("count_wrap", program_counter, k % 256);
        end

        do_jump(8'h10);
        check("jump_abs", program_counter, 32'h10);
        do_call(8'h40);
        check("call_pc", program_counter, 32'h40);
        check("call_depth", stack_depth, 1);
        step();
        check("after_call_inc", program_counter, 32'h41);
        do_return();
        check("ret_pc", program_counter, 32'h11);
        check("ret_depth", stack_depth, 0);

        do_jump(8'h05);
        do_branch(1'b1, 8'hFE, 3'b100, 2'b00);
        check("br_rel_always", program_counter, 32'h03);
        do_jump(8'h05);
        do_branch(1'b1, 8'hFE, 3'b001, 2'b00);
        check("br_flag0_clear", program_counter, 32'h06);
        do_branch(1'b0, 8'h80, 3'b010, 2'b10);
        check("br_flag1_set", program_counter, 32'h80);
        do_branch(1'b0, 8'h20, 3'b111, 2'b11);
        check("br_oor_inv", program_counter, 32'h20);
        do_branch(1'b0, 8'h90, 3'b011, 2'b11);
        check("br_oor_noinv", program_counter, 32'h21);
        do_branch(1'b0, 8'h90, 3'b101, 2'b01);
        check("br_flag0_inv", program_counter, 32'h22);

        jump_enable = 1'b1; call_enable = 1'b1; branch_destination = 8'h50; stall = 1'b1;
        step();
        check("stall_pc", program_counter, 32'h22);
        check("stall_depth", stack_depth, 0);
        step();
        check("stall_pc2", program_counter, 32'h22);
        stall = 1'b0;
        step();
        idle_controls();
        check("unstall_pc", program_counter, 32'h50);
        check("unstall_depth", stack_depth, 1);
        do_return();
        check("unstall_ret", program_counter, 32'h23);

        for (int i = 0; i < 4; i++) begin
            do_call(8'h60 + 8'(i));
            check("multi_call_pc", program_counter, 32'h60 + i);
            check("multi_call_depth", stack_depth, i + 1);
        end
        check("stack_full", stack_full, 1);
        do_call(8'h70);
        check("ovf_fault", fault, 1);
        check("ovf_cause", fault_cause, 2'b01);
        check("ovf_pc", program_counter, 32'h63);
        check("ovf_depth", stack_depth, 4);
        jump_enable = 1'b1; branch_destination = 8'h33;
        step();
        idle_controls();
        check("fault_frozen_pc", program_counter, 32'h63);
        fault_clear = 1'b1;
        step();
        idle_controls();
        check("clr_fault", fault, 0);
        check("clr_pc", program_counter, 32'h00);
        check("clr_depth", stack_depth, 0);
        check("clr_cause", fault_cause, 0);
        do_jump(8'h44);
        check("idle_ignores_jump", program_counter, 32'h00);

        system_start = 1'b1;
        step();
        system_start = 1'b0;
        do_return();
        check("udf_fault", fault, 1);
        check("udf_cause", fault_cause, 2'b10);
        check("udf_pc", program_counter, 32'h00);
        fault_clear = 1'b1;
        step();
        idle_controls();
        system_start = 1'b1;
        step();
        system_start = 1'b0;

        do_jump(8'hFF);
        do_call(8'h10);
        check("wrap_call_pc", program_counter, 32'h10);
        do_return();
        check("wrap_ret_pc", program_counter, 32'h00);

        clk_en = 1'b0;
        step();
        check("clken_hold", program_counter, 32'h00);
        clk_en = 1'b1;
        system_enabled = 1'b0;
        step();
        check("disabled_hold", program_counter, 32'h00);
        system_enabled = 1'b1;
        step();
        step();
        check("resume_pc", program_counter, 32'h02);

        do_call(8'h77);
        clk_en = 1'b0; stall = 1'b1; sync_rst = 1'b1;
        step();
        sync_rst = 1'b0; clk_en = 1'b1; stall = 1'b0;
        check("midrst_pc", program_counter, 32'h00);
        check("midrst_fault", fault, 0);
        check("midrst_depth", stack_depth, 0);
        step();
        check("midrst_idle", program_counter, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
